// File: rtl/pim_conv_bitslice_acc.sv
// Bit-sliced PIM convolution sequencer: slices one activation window, walks every
// (input slice, kernel slice) pair through a shared crossbar and shift-accumulates the psums.
module pim_conv_bitslice_acc #(
    parameter int unsigned NUM_TAPS   = 25,
    parameter int unsigned DATA_W     = 6,
    parameter int unsigned SLICE_W    = 3,
    parameter int unsigned NUM_KSLICE = 2,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned PSUM_W     = 6,
    parameter int unsigned ACC_W      = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_TAPS*DATA_W-1:0]   in_window,
    input  logic [ADDR_W-1:0]            in_base_addr,
    output logic                         xb_req,
    input  logic                         xb_ack,
    output logic [NUM_TAPS*SLICE_W-1:0]  xb_feature,
    output logic [ADDR_W-1:0]            xb_addr,
    input  logic [PSUM_W-1:0]            xb_psum,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic                         out_sat
);

    localparam int unsigned NIS    = DATA_W / SLICE_W;
    localparam int unsigned IW     = (NIS > 1) ? $clog2(NIS) : 1;
    localparam int unsigned KW     = (NUM_KSLICE > 1) ? $clog2(NUM_KSLICE) : 1;
    localparam int unsigned MAX_SH = (NIS + NUM_KSLICE - 2) * SLICE_W;
    localparam int unsigned SUM_W  =
        ((ACC_W > PSUM_W + MAX_SH) ? ACC_W : PSUM_W + MAX_SH) + 1;
    localparam logic [IW-1:0]    I_LAST  = IW'(NIS - 1);
    localparam logic [KW-1:0]    K_LAST  = KW'(NUM_KSLICE - 1);
    localparam logic [SUM_W-1:0] ACC_MAX = (SUM_W'(1) << ACC_W) - SUM_W'(1);

    if (DATA_W % SLICE_W != 0) begin : gen_bad_slice
        $error("DATA_W must be a multiple of SLICE_W");
    end

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e                        state_q, state_d;
    logic [NUM_TAPS*DATA_W-1:0]    window_q, window_d;
    logic [ADDR_W-1:0]             base_q, base_d;
    logic [IW-1:0]                 i_q, i_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [ACC_W-1:0]              acc_q, acc_d;
    logic [ACC_W-1:0]              data_q, data_d;
    logic                          sat_q, sat_d;
    logic [SUM_W-1:0]              sum;
    int unsigned                   shamt;

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        base_d   = base_q;
        i_d      = i_q;
        k_d      = k_q;
        acc_d    = acc_q;
        data_d   = data_q;
        sat_d    = sat_q;
        shamt    = (32'(i_q) + 32'(k_q)) * SLICE_W;
        // Sum is wide enough that the largest shifted psum cannot wrap before the clamp test.
        sum      = SUM_W'(acc_q) + (SUM_W'(xb_psum) << shamt);
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    window_d = in_window;
                    base_d   = in_base_addr;
                    acc_d    = '0;
                    sat_d    = 1'b0;
                    i_d      = '0;
                    k_d      = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (xb_ack) begin
                    if (sum > ACC_MAX) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (i_q == I_LAST) begin
                            data_d  = acc_d;
                            state_d = StDone;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            window_q <= '0;
            base_q   <= '0;
            i_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            data_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            base_q   <= base_d;
            i_q      <= i_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            sat_q    <= sat_d;
        end
    end

    // Slice i of every latched tap, tap 0 kept in the MSBs.
    always_comb begin
        xb_feature = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            xb_feature[(NUM_TAPS-1-t)*SLICE_W +: SLICE_W] =
                window_q[(NUM_TAPS-1-t)*DATA_W + 32'(i_q)*SLICE_W +: SLICE_W];
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign xb_req    = (state_q == StReq);
    assign out_valid = (state_q == StDone);
    assign xb_addr   = base_q + ADDR_W'(k_q);
    assign out_data  = data_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_pim_conv_bitslice_acc.sv
// Directed bench: default instance for sequencing/handshakes, ACC_W=10 instance for saturation.
module tb_pim_conv_bitslice_acc;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [149:0] in_window = '0;
    logic [4:0]   in_base_addr = '0;
    logic         xb_req, xb_ack = 1'b0;
    logic [74:0]  xb_feature;
    logic [4:0]   xb_addr;
    logic [5:0]   xb_psum = '0;
    logic         out_valid, out_ready = 1'b0;
    logic [17:0]  out_data;
    logic         out_sat;

    logic         s_in_valid = 1'b0, s_in_ready;
    logic         s_xb_req;
    logic [74:0]  s_xb_feature;
    logic [4:0]   s_xb_addr;
    logic         s_out_valid, s_out_ready = 1'b0;
    logic [9:0]   s_out_data;
    logic         s_out_sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pim_conv_bitslice_acc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_window(in_window), .in_base_addr(in_base_addr), .xb_req(xb_req),
        .xb_ack(xb_ack), .xb_feature(xb_feature), .xb_addr(xb_addr), .xb_psum(xb_psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    pim_conv_bitslice_acc #(.ACC_W(10)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_window({25{6'b111111}}), .in_base_addr(5'd3), .xb_req(s_xb_req),
        .xb_ack(1'b1), .xb_feature(s_xb_feature), .xb_addr(s_xb_addr), .xb_psum(6'd63),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_sat(s_out_sat)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ps packs the psums in pair order, pair 0 in the LSBs.
    task automatic run_window(input logic [4:0] base, input logic [5:0] tap,
                              input logic [23:0] ps, input int max_dly, input int hold,
                              input logic [17:0] exp_data, input bit chk_lat);
        logic [74:0] f_exp;
        logic [4:0]  a_exp;
        int          lat;
        int          dly;
        check_eq("in_ready_idle", in_ready, 1);
        in_valid     = 1'b1;
        in_window    = {25{tap}};
        in_base_addr = base;
        tick;
        in_valid = 1'b0;
        lat      = 1;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                f_exp = (i == 0) ? {25{tap[2:0]}} : {25{tap[5:3]}};
                a_exp = base + 5'(k);
                dly   = (max_dly > 0) ? int'($urandom_range(0, max_dly)) : 0;
                for (int d = 0; d < dly; d++) begin
                    check_eq("req_wait", xb_req, 1);
                    check_eq("feature_wait", xb_feature, f_exp);
                    check_eq("addr_wait", xb_addr, a_exp);
                    tick;
                    lat++;
                end
                check_eq("req", xb_req, 1);
                check_eq("in_ready_busy", in_ready, 0);
                check_eq("feature", xb_feature, f_exp);
                check_eq("addr", xb_addr, a_exp);
                xb_ack  = 1'b1;
                xb_psum = ps[(i*2+k)*6 +: 6];
                tick;
                lat++;
                xb_ack = 1'b0;
            end
        end
        check_eq("out_valid", out_valid, 1);
        check_eq("req_done", xb_req, 0);
        check_eq("out_data", out_data, exp_data);
        check_eq("out_sat", out_sat, 0);
        if (chk_lat) check_eq("latency", lat, 5);
        for (int h = 0; h < hold; h++) begin
            tick;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, exp_data);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check_eq("valid_drop", out_valid, 0);
        check_eq("in_ready_after", in_ready, 1);
        check_eq("data_retained", out_data, exp_data);
    endtask

    initial begin
        bit seen;
        tick;
        tick;
        rst = 1'b0;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_req", xb_req, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_sat", out_sat, 0);

        // Ack and out_ready while idle must not move anything.
        xb_ack    = 1'b1;
        out_ready = 1'b1;
        tick;
        tick;
        xb_ack    = 1'b0;
        out_ready = 1'b0;
        check_eq("idle_ack_req", xb_req, 0);
        check_eq("idle_valid", out_valid, 0);

        run_window(5'd4, 6'b101011, {6'd4, 6'd3, 6'd2, 6'd1}, 0, 0, 18'd297, 1'b1);
        run_window(5'd31, 6'b101011, {6'd4, 6'd3, 6'd2, 6'd1}, 3, 10, 18'd297, 1'b0);
        run_window(5'd9, 6'b110001, {6'd2, 6'd7, 6'd0, 6'd5}, 2, 1, 18'd189, 1'b0);

        // Reset in the middle of a window, with ack held high through it.
        in_valid     = 1'b1;
        in_window    = {25{6'b010101}};
        in_base_addr = 5'd12;
        tick;
        in_valid = 1'b0;
        xb_ack   = 1'b1;
        xb_psum  = 6'd9;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_eq("midrst_req", xb_req, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_data", out_data, 0);
        tick;
        xb_ack = 1'b0;
        check_eq("midrst_stale_ack", xb_req, 0);
        run_window(5'd7, 6'b101011, {6'd4, 6'd3, 6'd2, 6'd1}, 0, 0, 18'd297, 1'b1);

        // Saturating instance: 63 * (1 + 8 + 8 + 64) = 5103 > 1023.
        check_eq("sat_in_ready", s_in_ready, 1);
        s_in_valid = 1'b1;
        tick;
        s_in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (s_out_valid) seen = 1'b1;
            else tick;
        end
        check_eq("sat_valid_seen", seen, 1);
        check_eq("sat_data", s_out_data, 10'd1023);
        check_eq("sat_flag", s_out_sat, 1);
        s_out_ready = 1'b1;
        tick;
        s_out_ready = 1'b0;
        check_eq("sat_valid_drop", s_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pim_conv_bitslice_acc.md
Name: pim_conv_bitslice_acc

Overview:
- Next-generation bit-sliced PIM convolution sequencer; supersedes the fixed 5x5/6-bit four-unit slice adder.
- Accepts one flattened window of NUM_TAPS activations and decomposes it into input bit-slices.
- Issues one crossbar request per (input slice, kernel slice) pair and shift-accumulates the returned ADC partial sums into a saturating result.
- Sits between the window buffer and the pooling/activation stage; drives one shared crossbar tile through a req/ack handshake.

Parameters:
- NUM_TAPS, 25: activations per window (5x5 kernel).
- DATA_W, 6: activation width.
- SLICE_W, 3: input bit-slice width; also the weight bits per kernel-slice column.
- NUM_KSLICE, 2: kernel slices stored at consecutive crossbar addresses.
- ADDR_W, 5: crossbar address width.
- PSUM_W, 6: ADC output precision.
- ACC_W, 18: accumulator and output width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  window valid.
- in_ready  out  1  block can accept a window.
- in_window  in  NUM_TAPS*DATA_W  activations; tap 0 in the MSBs.
- in_base_addr  in  ADDR_W  crossbar address of kernel slice 0.
- xb_req  out  1  crossbar request.
- xb_ack  in  1  crossbar result valid; completes the request.
- xb_feature  out  NUM_TAPS*SLICE_W  current input slice; tap 0 in the MSBs.
- xb_addr  out  ADDR_W  current crossbar row address.
- xb_psum  in  PSUM_W  unsigned partial sum; sampled when xb_req&xb_ack.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  accumulated convolution result.
- out_sat  out  1  accumulator saturated during this window.

Behaviour:
- Elaboration error if DATA_W % SLICE_W != 0. NIS = DATA_W/SLICE_W.
- Reset (rst sampled high on a clk edge): state IDLE; in_ready=1; xb_req=0; out_valid=0; out_data=0; out_sat=0; acc=0; counters i=k=0. Reset mid-operation abandons the window immediately. No stale ack is consumed after reset.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_window and in_base_addr, clear acc, out_sat, i and k; go REQ next cycle.
- REQ:
  - in_ready=0, xb_req=1.
  - xb_feature = bits [(i+1)*SLICE_W-1 : i*SLICE_W] of every latched tap.
  - xb_addr = base_addr + k, modulo 2^ADDR_W (wraps).
  - xb_feature and xb_addr are stable while waiting for ack.
  - On ack: acc <= sat(acc + (zero-extended xb_psum << ((i+k)*SLICE_W))).
  - Pair order: k inner, i outer: (0,0),(0,1),(1,0),(1,1)...
  - xb_req stays high across consecutive pairs; the next pair is presented the cycle after the ack.
  - After the ack of pair (NIS-1, NUM_KSLICE-1): go DONE.
- Saturation: if the true sum exceeds 2^ACC_W-1, acc clamps to all-ones and out_sat sets. out_sat stays set for the rest of the window; later adds keep all-ones.
- DONE:
  - out_valid=1; out_data=acc and out_sat are held stable until the handshake.
  - On out_ready: go IDLE; out_valid=0 next cycle. out_data retains its value.
- Latency with xb_ack tied high: accept at cycle 0, requests in cycles 1..NIS*NUM_KSLICE, out_valid in cycle NIS*NUM_KSLICE+1. With defaults that is cycle 5.
- Throughput: one window per NIS*NUM_KSLICE+2 cycles. No accept occurs while busy; no overlap between windows.
- xb_ack while xb_req=0 is ignored.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Defaults, ack tied high, psums 1,2,3,4 in pair order -> xb_addr sequence b, b+1, b, b+1; out_data=297 (1+16+24+256); out_valid at cycle 5; out_sat=0.
- in_window taps all 6'b101_011 -> xb_feature is 25 copies of 3'b011 for i=0, then 25 copies of 3'b101 for i=1.
- ACC_W=10, all psums 63 -> true sum 5103; out_data=1023; out_sat=1.
- xb_ack delayed 0..3 random cycles, psums 1,2,3,4 -> same result 297; xb_feature and xb_addr never change while xb_req is high without ack.
- in_base_addr=31 (ADDR_W=5) -> xb_addr sequence 31, 0, 31, 0 (wraps).
- out_ready held low 10 cycles, then pulsed -> out_valid and out_data stable throughout; in_ready=1 the cycle after the handshake. rst asserted during REQ -> next cycle xb_req=0, in_ready=1, out_valid=0; a following window then computes correctly.
